// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back arbiter.
//   ADDR_W / DATA_W : register index and data widths of the register file
//   WB_DEPTH        : default entries per producer FIFO (power of two, >= 2)
//   SEQ_W           : width of the age stamp; one bit more than needed to
//                     number every entry that can be queued at once, so the
//                     sign of a difference orders any two live stamps.
//   wb_entry_t      : one queued write-back {rd, data, seq}
//   seq_older(a, b) : 1 when stamp a was issued before stamp b
package rf_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 64;
    localparam int WB_DEPTH = 2;
    localparam int SEQ_W    = $clog2(2 * WB_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } wb_entry_t;

    // Stamps wrap; the top bit of the modular difference is the sign.
    function automatic logic seq_older(input logic [SEQ_W-1:0] a,
                                       input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] diff;
        diff = a - b;
        return diff[SEQ_W-1];
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-producer write-back FIFO.
//   clk, reset     : clock, synchronous active-high flush
//   push_i         : enqueue push_entry_i (ignored while full)
//   pop_i          : dequeue head_o (ignored while empty)
//   head_o         : oldest entry
//   empty_o        : no entries held
//   count_o        : number of entries held (0..DEPTH)
//   ent_valid_o    : per-slot occupancy, for the pending-write compare
//   ent_rd_o       : per-slot destination register
module wb_fifo import rf_pkg::*; #(
    parameter  int DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push_i,
    input  wb_entry_t                      push_entry_i,
    input  logic                           pop_i,
    output wb_entry_t                      head_o,
    output logic                           empty_o,
    output logic [CNT_W-1:0]               count_o,
    output logic [DEPTH-1:0]               ent_valid_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]   ent_rd_o
);

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               full;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        ent_valid_o = '0;
        ent_rd_o    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid_o[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
            ent_rd_o[i]    = mem_q[i].rd;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
//   clk, reset                    : clock, synchronous active-high reset
//   wbN_valid/ready/rd/data       : producer N request (0 = ALU, 1 = load)
//   regWrite/writeReg/writeData   : registered register-file write port
//   readReg1/2, busy1/2           : decode operands and pending-write flags
//   idle                          : both FIFOs empty and no write in flight
// Handshake: a request transfers at a posedge where wbN_valid && wbN_ready.
// The producer holds rd/data while valid and not yet accepted; ready depends
// only on the FIFO count, never on valid or on a same-cycle pop.
module rf_wb_arbiter #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int DEPTH  = rf_pkg::WB_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb0_valid,
    output logic              wb0_ready,
    input  logic [ADDR_W-1:0] wb0_rd,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb1_valid,
    output logic              wb1_ready,
    input  logic [ADDR_W-1:0] wb1_rd,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic              busy1,
    output logic              busy2,
    output logic              idle
);
    import rf_pkg::wb_entry_t;
    import rf_pkg::seq_older;
    import rf_pkg::SEQ_W;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t                  in0, in1, head0, head1;
    logic                       empty0, empty1, push0, push1;
    logic                       grant0, grant1;
    logic [CNT_W-1:0]           count0, count1;
    logic [DEPTH-1:0]           vld0, vld1;
    logic [DEPTH-1:0][ADDR_W-1:0] erd0, erd1;

    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              rr_q, rr_d;
    logic              regWrite_q, regWrite_d;
    logic [ADDR_W-1:0] writeReg_q, writeReg_d;
    logic [DATA_W-1:0] writeData_q, writeData_d;

    assign wb0_ready = (count0 < CNT_W'(DEPTH));
    assign wb1_ready = (count1 < CNT_W'(DEPTH));
    assign push0     = wb0_valid && wb0_ready;
    assign push1     = wb1_valid && wb1_ready;

    // Port 0 takes the current stamp; port 1 follows it when both accept.
    assign in0   = '{rd: wb0_rd, data: wb0_data, seq: seq_q};
    assign in1   = '{rd: wb1_rd, data: wb1_data,
                     seq: push0 ? seq_q + 1'b1 : seq_q};
    assign seq_d = seq_q + SEQ_W'(push0) + SEQ_W'(push1);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .reset(reset), .push_i(push0), .push_entry_i(in0),
        .pop_i(grant0), .head_o(head0), .empty_o(empty0), .count_o(count0),
        .ent_valid_o(vld0), .ent_rd_o(erd0)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .reset(reset), .push_i(push1), .push_entry_i(in1),
        .pop_i(grant1), .head_o(head1), .empty_o(empty1), .count_o(count1),
        .ent_valid_o(vld1), .ent_rd_o(erd1)
    );

    // Same-register heads must retire oldest first so the final value wins;
    // only genuinely independent heads consume a round-robin turn.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        rr_d   = rr_q;
        if (!empty0 && !empty1) begin
            if (head0.rd == head1.rd) begin
                if (seq_older(head0.seq, head1.seq)) grant0 = 1'b1;
                else                                 grant1 = 1'b1;
            end else begin
                if (rr_q) grant1 = 1'b1;
                else      grant0 = 1'b1;
                rr_d = ~rr_q;
            end
        end else if (!empty0) begin
            grant0 = 1'b1;
        end else if (!empty1) begin
            grant1 = 1'b1;
        end
    end

    always_comb begin
        regWrite_d  = 1'b0;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        if (grant0) begin
            regWrite_d  = (head0.rd != '0);
            writeReg_d  = head0.rd;
            writeData_d = head0.data;
        end else if (grant1) begin
            regWrite_d  = (head1.rd != '0);
            writeReg_d  = head1.rd;
            writeData_d = head1.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q       <= '0;
            rr_q        <= 1'b0;
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
        end else begin
            seq_q       <= seq_d;
            rr_q        <= rr_d;
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
        end
    end

    // x0 is never pending; otherwise any queued entry or the in-flight write.
    function automatic logic pending(
        input logic [ADDR_W-1:0]              r,
        input logic [DEPTH-1:0]               v0,
        input logic [DEPTH-1:0][ADDR_W-1:0]   rd0,
        input logic [DEPTH-1:0]               v1,
        input logic [DEPTH-1:0][ADDR_W-1:0]   rd1,
        input logic                           rw,
        input logic [ADDR_W-1:0]              wr
    );
        logic hit;
        hit = rw && (wr == r);
        for (int i = 0; i < DEPTH; i++) begin
            if (v0[i] && rd0[i] == r) hit = 1'b1;
            if (v1[i] && rd1[i] == r) hit = 1'b1;
        end
        return (r != '0) && hit;
    endfunction

    assign busy1 = pending(readReg1, vld0, erd0, vld1, erd1, regWrite_q, writeReg_q);
    assign busy2 = pending(readReg2, vld0, erd0, vld1, erd1, regWrite_q, writeReg_q);

    assign regWrite  = regWrite_q;
    assign writeReg  = writeReg_q;
    assign writeData = writeData_q;
    assign idle      = empty0 && empty1 && !regWrite_q;

endmodule
